clause_mask_streamer: RTL and testbench
=======================================

# clause_mask_streamer

- Sits directly upstream of each SAT node and supplies its clause-by-clause substitution stream.
- Holds the CNF clause table, one entry per clause, each entry CLAUSE_LENGTH literals.
- Accepts a variable assignment and scans the table to check whether the variable occurs anywhere.
- If it occurs, emits one SubstitutionMask beat per clause. If not, emits a single VariableNotFound beat.

## Interface
Parameters:
- NUM_CLAUSES, 16, clauses in table (≥2); IDX_W = $clog2(NUM_CLAUSES)
- CLAUSE_LENGTH, 3, literals per clause
- VAR_WIDTH, 8, variable id width; id 0 reserved = empty literal slot

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- cfg_we  in  1  clause table write strobe
- cfg_addr  in  IDX_W  clause index written
- cfg_lit_var  in  CLAUSE_LENGTH*VAR_WIDTH  literal variable ids; literal i at bits [i*VAR_WIDTH +: VAR_WIDTH]
- cfg_lit_neg  in  CLAUSE_LENGTH  literal i negated when 1
- cfg_err  out  1  one-cycle pulse: write dropped because block busy
- req_valid  in  1  assignment request
- req_var  in  VAR_WIDTH  variable being assigned
- req_value  in  1  assigned value
- req_ready  out  1  high only in IDLE
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_msg_type  out  2  01 Fork (never driven), 10 SubstitutionMask, 11 VariableNotFound
- out_var  out  VAR_WIDTH  latched req_var
- out_mask  out  CLAUSE_LENGTH  bit i = 1 iff literal i is satisfied by the assignment
- out_clause_idx  out  IDX_W  clause of current beat
- out_last  out  1  final beat of a stream
- abort  in  1  present only with MASK_STREAM_ABORT_EN

## Operation
- States: IDLE, SCAN, EMIT, NOTFOUND.
- IDLE:
  - req_ready=1.
  - req_valid latches req_var and req_value, clears found and idx, and moves to SCAN.
- SCAN:
  - Examines clause idx each cycle.
  - found |= any literal var == latched var; var 0 never matches.
  - At idx == NUM_CLAUSES-1: go to EMIT if found (after this clause), else NOTFOUND.
  - idx resets to 0 in both cases.
- EMIT:
  - out_valid=1, out_msg_type=10, out_clause_idx=idx.
  - out_mask[i] = (lit_var[idx][i] == var) && (lit_neg[idx][i] ^ value).
  - On out_valid && out_ready: idx++.
  - out_last=1 at idx == NUM_CLAUSES-1; after that beat is accepted, go to IDLE.
- NOTFOUND:
  - One beat: out_valid=1, msg 11, mask 0, idx 0, out_last=1.
  - After acceptance, go to IDLE.
- Writes:
  - cfg_we in IDLE updates entry cfg_addr.
  - cfg_we in any other state is dropped and cfg_err pulses the next cycle.
  - cfg_addr ≥ NUM_CLAUSES is dropped with cfg_err.
- Outputs are held stable while out_valid && !out_ready.
- Arithmetic: idx is IDX_W bits and never wraps past NUM_CLAUSES-1. Comparisons are exact VAR_WIDTH equality.

## Timing
- Reset values:
  - cfg_err=0, req_ready=0 during reset then 1, out_valid=0, out_msg_type=00, out_var=0, out_mask=0, out_clause_idx=0, out_last=0.
  - State IDLE; table entries all var 0 and neg 0.
- Request accepted at edge T. SCAN runs T+1..T+NUM_CLAUSES.
- The first output beat is visible at T+NUM_CLAUSES+1.
- With out_ready held high, EMIT takes NUM_CLAUSES cycles; req_ready returns the cycle after the last accept.
- Same-cycle cfg_we and req_valid in IDLE: the write commits first, and the scan sees the new entry.
- Reset asserted mid-stream: the next edge forces all reset values and drops the partial stream with no final beat.

## Configuration
- MASK_STREAM_ABORT_EN defined:
  - Adds the abort input.
  - abort high in SCAN, EMIT or NOTFOUND forces IDLE at the next edge and clears out_valid.
  - A beat handshaking in the same cycle as abort is counted as delivered.
  - abort in IDLE has no effect and has priority over req_valid.
- Undefined: no abort port. A stream always completes or ends by reset.

## Test plan
- Clause 3 = {5, ¬7, 9}; all other clauses empty; req var=7 value=0.
  - First beat at T+17.
  - 16 SubstitutionMask beats; clause 3 mask=010, all others 000.
  - out_last only on idx 15.
- req var=42, absent from the table → exactly one beat: msg 11, out_last=1, at T+17; then req_ready=1.
- Backpressure: out_ready toggled 1,0,0,1… during EMIT → no beat skipped or duplicated; outputs stable while stalled.
- cfg_we during SCAN → cfg_err pulse; table unchanged; a subsequent request reflects the old contents.
- Same-cycle write of clause 0 = {7,0,0} and req var=7 value=1 → clause 0 mask=001.
- rst_n low for one cycle during EMIT at idx 6 → all outputs at reset values next cycle and table cleared. With MASK_STREAM_ABORT_EN, abort at idx 6 → IDLE next cycle, table retained.

Source files
------------

// File: rtl/clause_mask_streamer.sv
// clause_mask_streamer
// Holds the CNF clause table for one SAT node. For each variable assignment it
// first scans the table to see whether the variable occurs at all. If it does,
// it streams one SubstitutionMask beat per clause. If it does not, it emits a
// single VariableNotFound beat.
// Optional build macro: MASK_STREAM_ABORT_EN adds an abort input that drops an
// in-flight scan or stream and returns the block to IDLE.
module clause_mask_streamer #(
  parameter int NUM_CLAUSES   = 16,
  parameter int CLAUSE_LENGTH = 3,
  parameter int VAR_WIDTH     = 8,
  localparam int IDX_W        = $clog2(NUM_CLAUSES)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_we,
  input  logic [IDX_W-1:0]                   cfg_addr,
  input  logic [CLAUSE_LENGTH*VAR_WIDTH-1:0] cfg_lit_var,
  input  logic [CLAUSE_LENGTH-1:0]           cfg_lit_neg,
  output logic                               cfg_err,
  input  logic                               req_valid,
  input  logic [VAR_WIDTH-1:0]               req_var,
  input  logic                               req_value,
  output logic                               req_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [1:0]                         out_msg_type,
  output logic [VAR_WIDTH-1:0]               out_var,
  output logic [CLAUSE_LENGTH-1:0]           out_mask,
  output logic [IDX_W-1:0]                   out_clause_idx,
  output logic                               out_last
`ifdef MASK_STREAM_ABORT_EN
  ,
  input  logic                               abort
`endif
);

  localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(NUM_CLAUSES - 1);
  localparam logic [IDX_W:0]   C_NC_EXT  = (IDX_W + 1)'(NUM_CLAUSES);
  localparam logic [1:0]       C_MSG_SUB = 2'b10;
  localparam logic [1:0]       C_MSG_NF  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN     = 2'd1,
    ST_EMIT     = 2'd2,
    ST_NOTFOUND = 2'd3
  } state_t;

  // A literal slot matches only on exact id equality; id 0 marks an empty slot
  // and can never match, even if the request itself names variable 0.
  function automatic logic lit_hit(input logic [VAR_WIDTH-1:0] lit,
                                   input logic [VAR_WIDTH-1:0] v);
    return (v != '0) && (lit == v);
  endfunction

  // Clause table
  logic [CLAUSE_LENGTH*VAR_WIDTH-1:0] r_lit_var [NUM_CLAUSES];
  logic [CLAUSE_LENGTH-1:0]           r_lit_neg [NUM_CLAUSES];

  // Control state
  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_found;
  logic [VAR_WIDTH-1:0]   r_var;
  logic                   r_value;
  logic                   r_cfg_err;

  // Next-state and helper nets
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   w_found_nxt;
  logic [VAR_WIDTH-1:0]   w_var_nxt;
  logic                   w_value_nxt;
  logic                   w_abort;
  logic                   w_addr_ok;
  logic                   w_cfg_ok;
  logic                   w_scan_hit;
  logic [CLAUSE_LENGTH-1:0]           w_mask;
  logic [CLAUSE_LENGTH*VAR_WIDTH-1:0] w_row_var;
  logic [CLAUSE_LENGTH-1:0]           w_row_neg;

`ifdef MASK_STREAM_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Writes land only while idle and in range; anything else is reported.
  assign w_addr_ok = ({1'b0, cfg_addr} < C_NC_EXT);
  assign w_cfg_ok  = cfg_we && (r_state == ST_IDLE) && w_addr_ok;

  assign w_row_var = r_lit_var[r_idx];
  assign w_row_neg = r_lit_neg[r_idx];

  // Per-clause occurrence test and substitution mask for the clause at r_idx
  always_comb begin
    w_scan_hit = 1'b0;
    w_mask     = '0;
    for (int i = 0; i < CLAUSE_LENGTH; i++) begin
      if (lit_hit(w_row_var[i*VAR_WIDTH +: VAR_WIDTH], r_var)) begin
        w_scan_hit = 1'b1;
        w_mask[i]  = w_row_neg[i] ^ r_value;
      end
    end
  end

  // Clause table storage, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLAUSES; k++) begin
        r_lit_var[k] <= '0;
        r_lit_neg[k] <= '0;
      end
    end else if (w_cfg_ok) begin
      r_lit_var[cfg_addr] <= cfg_lit_var;
      r_lit_neg[cfg_addr] <= cfg_lit_neg;
    end
  end

  // Dropped-write pulse, visible the cycle after the offending strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
    end
  end

  assign cfg_err = r_cfg_err;

  // FSM state and scan/stream bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_var   <= '0;
      r_value <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_found <= w_found_nxt;
      r_var   <= w_var_nxt;
      r_value <= w_value_nxt;
    end
  end

  // Next-state logic: scan all clauses, then stream or report not-found
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_found_nxt = r_found;
    w_var_nxt   = r_var;
    w_value_nxt = r_value;
    unique case (r_state)
      ST_IDLE: begin
        // An abort seen while idle only blocks acceptance for that cycle.
        if (req_valid && !w_abort) begin
          w_var_nxt   = req_var;
          w_value_nxt = req_value;
          w_found_nxt = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_found_nxt = r_found | w_scan_hit;
        if (r_idx == C_LAST) begin
          w_idx_nxt   = '0;
          w_state_nxt = (r_found | w_scan_hit) ? ST_EMIT : ST_NOTFOUND;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (r_idx == C_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ST_NOTFOUND: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
    // Abort wins over every in-flight transition; a beat handshaking in the
    // same cycle has already been taken by the consumer.
    if (w_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end
  end

  // Output decode; outputs depend only on registered state and the table,
  // which cannot change outside IDLE, so a stalled beat stays stable.
  always_comb begin
    req_ready      = (r_state == ST_IDLE) && rst_n && !w_abort;
    out_valid      = 1'b0;
    out_msg_type   = 2'b00;
    out_var        = '0;
    out_mask       = '0;
    out_clause_idx = '0;
    out_last       = 1'b0;
    unique case (r_state)
      ST_EMIT: begin
        out_valid      = 1'b1;
        out_msg_type   = C_MSG_SUB;
        out_var        = r_var;
        out_mask       = w_mask;
        out_clause_idx = r_idx;
        out_last       = (r_idx == C_LAST);
      end
      ST_NOTFOUND: begin
        out_valid      = 1'b1;
        out_msg_type   = C_MSG_NF;
        out_var        = r_var;
        out_last       = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_clause_mask_streamer.sv
// Directed bench for clause_mask_streamer (default build, 16 clauses x 3 literals).
module tb_clause_mask_streamer;

  localparam int NC = 16;
  localparam int CL = 3;
  localparam int VW = 8;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [IW-1:0]   cfg_addr;
  logic [CL*VW-1:0] cfg_lit_var;
  logic [CL-1:0]   cfg_lit_neg;
  logic            cfg_err;
  logic            req_valid;
  logic [VW-1:0]   req_var;
  logic            req_value;
  logic            req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_msg_type;
  logic [VW-1:0]   out_var;
  logic [CL-1:0]   out_mask;
  logic [IW-1:0]   out_clause_idx;
  logic            out_last;

  int n_checks = 0;
  int n_pass   = 0;

  clause_mask_streamer #(
    .NUM_CLAUSES  (NC),
    .CLAUSE_LENGTH(CL),
    .VAR_WIDTH    (VW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_lit_var   (cfg_lit_var),
    .cfg_lit_neg   (cfg_lit_neg),
    .cfg_err       (cfg_err),
    .req_valid     (req_valid),
    .req_var       (req_var),
    .req_value     (req_value),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_msg_type  (out_msg_type),
    .out_var       (out_var),
    .out_mask      (out_mask),
    .out_clause_idx(out_clause_idx),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_clause(input logic [IW-1:0] a, input logic [VW-1:0] v0,
                           input logic [VW-1:0] v1, input logic [VW-1:0] v2,
                           input logic [CL-1:0] neg);
    cfg_we      = 1'b1;
    cfg_addr    = a;
    cfg_lit_var = {v2, v1, v0};
    cfg_lit_neg = neg;
  endtask

  // Issue a request (any pending cfg write goes in the same cycle) and check
  // the whole resulting stream with out_ready held high.
  task automatic stream_check(input logic [VW-1:0] v, input logic val,
                              input int mcl, input logic [CL-1:0] mmask,
                              input bit found);
    req_valid = 1'b1;
    req_var   = v;
    req_value = val;
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    cfg_we    = 1'b0;
    chk("scan_ready_low", req_ready, 0);
    repeat (NC - 1) tick();
    chk("no_beat_before_scan_done", out_valid, 0);
    tick();
    if (found) begin
      for (int k = 0; k < NC; k++) begin
        chk("beat_valid", out_valid, 1);
        chk("beat_msg", out_msg_type, 2'b10);
        chk("beat_var", out_var, v);
        chk("beat_idx", out_clause_idx, k);
        chk("beat_mask", out_mask, (k == mcl) ? mmask : 3'b000);
        chk("beat_last", out_last, (k == NC - 1) ? 1 : 0);
        tick();
      end
    end else begin
      chk("nf_valid", out_valid, 1);
      chk("nf_msg", out_msg_type, 2'b11);
      chk("nf_var", out_var, v);
      chk("nf_mask", out_mask, 0);
      chk("nf_idx", out_clause_idx, 0);
      chk("nf_last", out_last, 1);
      tick();
    end
    chk("post_valid", out_valid, 0);
    chk("post_ready", req_ready, 1);
  endtask

  initial begin
    bit   done;
    int   exp_idx;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_lit_var = '0; cfg_lit_neg = '0;
    req_valid = 1'b0; req_var = '0; req_value = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready_low", req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_high", req_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_msg", out_msg_type, 0);
    chk("rst_var", out_var, 0);
    chk("rst_mask", out_mask, 0);
    chk("rst_idx", out_clause_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // Clause 3 = {5, ~7, 9}
    wr_clause(4'd3, 8'd5, 8'd7, 8'd9, 3'b010);
    tick();
    cfg_we = 1'b0;
    chk("wr_idle_no_err", cfg_err, 0);

    // var 7 = 0 satisfies ~7 in clause 3 only
    stream_check(8'd7, 1'b0, 3, 3'b010, 1'b1);
    // var 42 absent
    stream_check(8'd42, 1'b0, 0, 3'b000, 1'b0);

    // Backpressure: var 9 = 1 satisfies literal 2 of clause 3
    req_valid = 1'b1; req_var = 8'd9; req_value = 1'b1; out_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (NC) tick();
    exp_idx = 0;
    for (int c = 0; c < 80 && exp_idx < NC; c++) begin
      out_ready = pat[c % 4];
      chk("bp_valid", out_valid, 1);
      chk("bp_idx", out_clause_idx, exp_idx);
      chk("bp_mask", out_mask, (exp_idx == 3) ? 3'b100 : 3'b000);
      chk("bp_last", out_last, (exp_idx == NC - 1) ? 1 : 0);
      if (out_ready) exp_idx++;
      tick();
    end
    chk("bp_all_beats", exp_idx, NC);
    chk("bp_post_valid", out_valid, 0);
    chk("bp_post_ready", req_ready, 1);

    // Write during SCAN is dropped
    req_valid = 1'b1; req_var = 8'd5; req_value = 1'b1; out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    wr_clause(4'd3, 8'd0, 8'd0, 8'd0, 3'b000);
    tick();
    cfg_we = 1'b0;
    chk("busy_wr_err", cfg_err, 1);
    tick();
    chk("busy_wr_err_pulse", cfg_err, 0);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (out_valid && out_last) done = 1'b1;
      tick();
    end
    chk("drain_done", done, 1);
    // Old contents still present: var 5 = 1 satisfies literal 0 of clause 3
    stream_check(8'd5, 1'b1, 3, 3'b001, 1'b1);

    // Same-cycle write of clause 0 = {7,0,0} with request var 7 = 1
    wr_clause(4'd0, 8'd7, 8'd0, 8'd0, 3'b000);
    stream_check(8'd7, 1'b1, 0, 3'b001, 1'b1);

    // Reset during EMIT at idx 6
    req_valid = 1'b1; req_var = 8'd7; req_value = 1'b0; out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (NC) tick();
    repeat (6) tick();
    chk("pre_rst_idx", out_clause_idx, 6);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_msg", out_msg_type, 0);
    chk("midrst_var", out_var, 0);
    chk("midrst_mask", out_mask, 0);
    chk("midrst_idx", out_clause_idx, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_ready", req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", req_ready, 1);
    // Table cleared: var 7 no longer found
    stream_check(8'd7, 1'b0, 0, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
